// File: rtl/prime_detector_seq.sv
// Sequential prime detector: screens trivial operands, then does odd trial division
// with a WIDTH-cycle restoring divider per candidate divisor.
module prime_detector_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic             is_prime,
  output logic [WIDTH-1:0] factor
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);
  localparam logic [IW-1:0]    TOP_BIT = IW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCREEN = 3'd1,
    SQ     = 3'd2,
    DIV    = 3'd3,
    TEST   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] d;
  logic [WIDTH:0]   rem;
  logic [IW-1:0]    bit_idx;

  logic [2*WIDTH-1:0] d_sq;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_next;

  // rem stays below d between steps, so its top bit is always zero before the shift.
  assign d_sq      = {{WIDTH{1'b0}}, d} * {{WIDTH{1'b0}}, d};
  assign rem_shift = {rem[WIDTH-1:0], n[bit_idx]};
  assign rem_next  = (rem_shift >= {1'b0, d}) ? (rem_shift - {1'b0, d}) : rem_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      is_prime <= 1'b0;
      factor   <= '0;
      n        <= '0;
      d        <= '0;
      rem      <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            n     <= n_in;
            busy  <= 1'b1;
            state <= SCREEN;
          end
        end

        SCREEN: begin
          if (n < TWO) begin
            is_prime <= 1'b0;
            factor   <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end else if ((n == TWO) || (n == THREE)) begin
            is_prime <= 1'b1;
            factor   <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end else if (!n[0]) begin
            is_prime <= 1'b0;
            factor   <= TWO;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            d     <= THREE;
            state <= SQ;
          end
        end

        SQ: begin
          if (d_sq > {{WIDTH{1'b0}}, n}) begin
            is_prime <= 1'b1;
            factor   <= '0;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            rem     <= '0;
            bit_idx <= TOP_BIT;
            state   <= DIV;
          end
        end

        DIV: begin
          rem <= rem_next;
          if (bit_idx == '0) begin
            state <= TEST;
          end else begin
            bit_idx <= bit_idx - 1'b1;
          end
        end

        TEST: begin
          if (rem == '0) begin
            is_prime <= 1'b0;
            factor   <= d;
            done     <= 1'b1;
            state    <= DONE;
          end else begin
            d     <= d + TWO;
            state <= SQ;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prime_detector_seq.sv
// Randomized and directed bench for prime_detector_seq at WIDTH=8 and WIDTH=16,
// checked against an arithmetic trial-division reference model.
module tb_prime_detector_seq;

  localparam int LIMIT = 5000;

  logic        clk;
  logic        rst_n;
  logic        start8, start16;
  logic [7:0]  n8;
  logic [15:0] n16;
  logic        busy8, done8, prime8;
  logic [7:0]  factor8;
  logic        busy16, done16, prime16;
  logic [15:0] factor16;

  logic        use_wide;
  logic        sel_busy, sel_done, sel_prime;
  logic [15:0] sel_factor;

  int total;
  int bad;

  prime_detector_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .n_in(n8),
    .busy(busy8), .done(done8), .is_prime(prime8), .factor(factor8)
  );

  prime_detector_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .n_in(n16),
    .busy(busy16), .done(done16), .is_prime(prime16), .factor(factor16)
  );

  assign sel_busy   = use_wide ? busy16 : busy8;
  assign sel_done   = use_wide ? done16 : done8;
  assign sel_prime  = use_wide ? prime16 : prime8;
  assign sel_factor = use_wide ? factor16 : {8'b0, factor8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Plain trial division; latency follows from how many divisors get tried.
  function automatic void ref_model(input int n, input int w, output int prime,
                                    output int fac, output int lat);
    int k;
    prime = 1;
    fac   = 0;
    lat   = 2;
    k     = 0;
    if (n < 2) begin
      prime = 0;
    end else if (n == 2 || n == 3) begin
      prime = 1;
    end else if (n % 2 == 0) begin
      prime = 0;
      fac   = 2;
    end else begin
      for (int d = 3; d * d <= n; d += 2) begin
        k++;
        if (n % d == 0) begin
          prime = 0;
          fac   = d;
          break;
        end
      end
      lat = prime ? (3 + k * (w + 2)) : (2 + k * (w + 2));
    end
  endfunction

  task automatic applyStimulus(input bit wide, input int n, input int inject_edge,
                               output int lat, output int prime, output int fac,
                               output int busy_err, output int post_err);
    use_wide = wide;
    @(negedge clk);
    if (wide) begin start16 = 1'b1; n16 = n[15:0]; end
    else      begin start8  = 1'b1; n8  = n[7:0];  end
    lat = -1; prime = -1; fac = -1; busy_err = 0; post_err = 0;
    for (int e = 1; e <= LIMIT; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1 || e == inject_edge + 1) begin
        start8  = 1'b0;
        start16 = 1'b0;
      end
      if (e == 2) begin
        n8  = 8'($urandom);
        n16 = 16'($urandom);
      end
      if (e == inject_edge) begin
        if (wide) begin start16 = 1'b1; n16 = 16'd200; end
        else      begin start8  = 1'b1; n8  = 8'd200;  end
      end
      if (!sel_busy) busy_err++;
      if (sel_done) begin
        lat   = e;
        prime = int'(sel_prime);
        fac   = int'(sel_factor);
        break;
      end
    end
    if (lat > 0) begin
      repeat (3) begin
        @(negedge clk);
        if (sel_done || sel_busy || int'(sel_prime) != prime || int'(sel_factor) != fac)
          post_err++;
      end
    end
  endtask

  task automatic runCase(input bit wide, input int n, input int inject_edge);
    int lat, prime, fac, busy_err, post_err;
    int exp_prime, exp_fac, exp_lat;
    string tag;
    ref_model(n, wide ? 16 : 8, exp_prime, exp_fac, exp_lat);
    applyStimulus(wide, n, inject_edge, lat, prime, fac, busy_err, post_err);
    tag = $sformatf("w%0d_n%0d", wide ? 16 : 8, n);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_is_prime"}, prime, exp_prime);
    checkOutput({tag, "_factor"}, fac, exp_fac);
    checkOutput({tag, "_busy_low_early"}, busy_err, 0);
    checkOutput({tag, "_after_done"}, post_err, 0);
  endtask

  initial begin
    total = 0; bad = 0;
    use_wide = 1'b0;
    start8 = 1'b0; start16 = 1'b0; n8 = '0; n16 = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("reset_busy", int'(busy8), 0);
    checkOutput("reset_done", int'(done8), 0);
    checkOutput("reset_prime", int'(prime8), 0);
    checkOutput("reset_factor16", int'(factor16), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) runCase(1'b0, i, 0);
    runCase(1'b0, 9, 0);
    runCase(1'b0, 221, 0);
    runCase(1'b0, 255, 0);
    runCase(1'b0, 251, 0);
    runCase(1'b0, 251, 5);
    for (int i = 0; i < 20; i++) runCase(1'b0, int'($urandom_range(0, 255)), 0);

    // Leave a composite result held, then abort a 251 run mid-division.
    runCase(1'b0, 9, 0);
    use_wide = 1'b0;
    @(negedge clk);
    start8 = 1'b1; n8 = 8'd251;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    repeat (19) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", int'(busy8), 0);
    checkOutput("abort_done", int'(done8), 0);
    checkOutput("abort_prime", int'(prime8), 0);
    checkOutput("abort_factor", int'(factor8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    runCase(1'b0, 13, 0);

    runCase(1'b1, 65521, 0);
    runCase(1'b1, 65535, 0);
    for (int i = 0; i < 6; i++) runCase(1'b1, int'($urandom_range(0, 65535)), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
